// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec/mem sequencer for the X9 core
//
// Owns the program counter and steps each instruction through FETCH, DECODE,
// EXEC and MEM. It turns the control decoder's strobes into per-phase enables
// for the register file and the data memory.
//
// Optional feature: define SEQ_INSTR_COUNT_EN to build the saturating
// retired-instruction counter. Without it, instr_count_o is tied to 0.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset
//   start_i          begin execution at start_addr_i (accepted in IDLE/DONE only)
//   start_addr_i     first instruction address
//   halt_i           current IR is a halt (sampled in DECODE)
//   branch_i         decoder Branch strobe
//   mem_read_i       decoder MemRead strobe
//   mem_write_i      decoder MemWrite strobe
//   reg_write_i      decoder RegWrite strobe
//   branch_taken_i   ALU condition result (sampled in EXEC)
//   branch_target_i  resolved branch target (sampled in EXEC)
//   mem_ready_i      data memory access complete (sampled in MEM)
//   pc_o             registered program counter
//   ir_load_o        load IR from ROM[pc_o]
//   mem_req_o        data memory request
//   mem_we_o         data memory write enable (only with mem_req_o)
//   rf_we_o          register-file write enable
//   busy_o           sequencer is running an instruction
//   done_o           program halted
//   instr_count_o    retired-instruction count
module instr_sequencer #(
  parameter int PCW  = 10,
  parameter int CNTW = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [PCW-1:0]  start_addr_i,
  input  logic            halt_i,
  input  logic            branch_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            reg_write_i,
  input  logic            branch_taken_i,
  input  logic [PCW-1:0]  branch_target_i,
  input  logic            mem_ready_i,
  output logic [PCW-1:0]  pc_o,
  output logic            ir_load_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            rf_we_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [CNTW-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           start_accept;
  logic           retire;

  // start is only honoured while the sequencer is parked.
  assign start_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
  // An instruction retires when it leaves EXEC, or leaves MEM on mem_ready.
  assign retire = (state_q == S_EXEC) || ((state_q == S_MEM) && mem_ready_i);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // halt wins over a memory op, which wins over ALU/branch.
        if (halt_i)                         state_d = S_DONE;
        else if (mem_read_i || mem_write_i) state_d = S_MEM;
        else                                state_d = S_EXEC;
      end
      S_EXEC: state_d = S_FETCH;
      S_MEM: begin
        if (mem_ready_i) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: busy/done/ir_load/mem_req depend on state only;
  // rf_we/mem_we additionally qualify the decoder strobes.
  always_comb begin
    ir_load_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    rf_we_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        busy_o    = 1'b1;
        ir_load_o = 1'b1;
      end
      S_DECODE: busy_o = 1'b1;
      S_EXEC: begin
        busy_o  = 1'b1;
        rf_we_o = reg_write_i;
      end
      S_MEM: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = mem_write_i;
        // Load data is only valid in the completing cycle.
        rf_we_o   = mem_ready_i && mem_read_i && reg_write_i;
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Program counter: updated on the edge leaving EXEC or MEM so the next
  // FETCH already addresses the new instruction. Increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (start_accept) begin
      pc_d = start_addr_i;
    end else if ((state_q == S_EXEC) && branch_i && branch_taken_i) begin
      pc_d = branch_target_i;
    end else if (retire) begin
      pc_d = pc_q + PCW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

`ifdef SEQ_INSTR_COUNT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Saturating count of retired instructions, cleared on an accepted start.
  always_comb begin
    cnt_d = cnt_q;
    if (start_accept) begin
      cnt_d = '0;
    end else if (retire && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count_o = cnt_q;
`else
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  localparam int PCW  = 10;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [PCW-1:0]  start_addr;
  logic            halt;
  logic            branch;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            branch_taken;
  logic [PCW-1:0]  branch_target;
  logic            mem_ready;
  logic [PCW-1:0]  pc;
  logic            ir_load;
  logic            mem_req;
  logic            mem_we;
  logic            rf_we;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] instr_count;

  int compared   = 0;
  int mismatched = 0;
  int req_cycles;
  int rf_pulses;

  always #5 clk = ~clk;

  instr_sequencer #(.PCW(PCW), .CNTW(CNTW)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .start_addr_i    (start_addr),
    .halt_i          (halt),
    .branch_i        (branch),
    .mem_read_i      (mem_read),
    .mem_write_i     (mem_write),
    .reg_write_i     (reg_write),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .mem_ready_i     (mem_ready),
    .pc_o            (pc),
    .ir_load_o       (ir_load),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .rf_we_o         (rf_we),
    .busy_o          (busy),
    .done_o          (done),
    .instr_count_o   (instr_count)
  );

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef SEQ_INSTR_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_dec();
    halt = 0; branch = 0; mem_read = 0; mem_write = 0; reg_write = 0;
    branch_taken = 0; branch_target = '0; mem_ready = 0;
  endtask

  // Runs one ALU/branch instruction starting in FETCH; ends in the next FETCH.
  task automatic do_alu(input logic [PCW-1:0] pc_exp, input logic br, input logic tk,
                        input logic [PCW-1:0] tgt, input logic rw);
    check("alu_fetch_ir_load", ir_load, 1);
    check("alu_fetch_pc", pc, pc_exp);
    branch = br; branch_taken = tk; branch_target = tgt; reg_write = rw;
    tick();
    check("alu_decode_ir_load", ir_load, 0);
    check("alu_decode_busy", busy, 1);
    tick();
    check("alu_exec_rf_we", rf_we, rw);
    check("alu_exec_mem_req", mem_req, 0);
    check("alu_exec_pc_hold", pc, pc_exp);
    tick();
    clear_dec();
  endtask

  initial begin
    reset = 1; start = 0; start_addr = '0;
    clear_dec();
    tick();
    check("rst_busy", busy, 0);
    check("rst_pc", pc, 0);
    tick();
    reset = 0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ir_load", ir_load, 0);

    // start at 5: three ALU instructions then halt
    start = 1; start_addr = 10'd5;
    tick();                                   // edge 1 -> FETCH
    start = 0;
    check("start_busy", busy, 1);
    check("start_pc", pc, 5);
    do_alu(10'd5, 0, 0, 10'd0, 1);            // edges 2..4
    do_alu(10'd6, 0, 0, 10'd0, 0);            // edges 5..7
    do_alu(10'd7, 0, 0, 10'd0, 1);            // edges 8..10
    check("halt_fetch_pc", pc, 8);
    halt = 1; mem_read = 1;                   // halt has priority over mem op
    tick();                                   // edge 11 DECODE
    check("halt_decode_done", done, 0);
    tick();                                   // edge 12 DONE
    clear_dec();
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_mem_req", mem_req, 0);
    check("halt_pc", pc, 8);
    check("halt_count", instr_count, exp_cnt(3));
    tick();
    check("done_hold", done, 1);

    // restart from DONE at 20; branch taken / not taken
    start = 1; start_addr = 10'd20;
    tick();
    start = 0;
    check("restart_done", done, 0);
    check("restart_count", instr_count, exp_cnt(0));
    do_alu(10'd20, 1, 1, 10'd3, 1);           // taken -> 3
    check("br_taken_pc", pc, 3);
    do_alu(10'd3, 0, 0, 10'd0, 0);
    do_alu(10'd4, 1, 1, 10'd20, 0);           // back to 20
    do_alu(10'd20, 1, 0, 10'd3, 1);           // not taken -> 21
    check("br_not_taken_pc", pc, 21);
    do_alu(10'd21, 0, 1, 10'd3, 1);           // taken without branch -> 22
    check("no_branch_pc", pc, 22);

    // start pulsed while busy is ignored
    start = 1; start_addr = 10'd100;
    do_alu(10'd22, 0, 0, 10'd0, 0);
    start = 0;
    check("start_busy_ignored_pc", pc, 23);

    // load with mem_ready low for 4 cycles
    mem_read = 1; reg_write = 1;
    tick();                                   // DECODE
    tick();                                   // MEM
    req_cycles = 0; rf_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req) req_cycles++;
      if (rf_we) rf_pulses++;
      check("load_wait_mem_we", mem_we, 0);
      tick();
    end
    mem_ready = 1;
    #1;
    if (mem_req) req_cycles++;
    if (rf_we) rf_pulses++;
    check("load_ready_rf_we", rf_we, 1);
    check("load_ready_pc_hold", pc, 23);
    tick();
    clear_dec();
    check("load_req_cycles", req_cycles, 5);
    check("load_rf_pulses", rf_pulses, 1);
    check("load_after_mem_req", mem_req, 0);
    check("load_pc", pc, 24);
    check("load_fetch", ir_load, 1);

    // store with mem_ready already high (ignored in DECODE)
    mem_write = 1; reg_write = 1; mem_ready = 1;
    tick();                                   // DECODE
    check("store_decode_mem_req", mem_req, 0);
    tick();                                   // MEM
    check("store_mem_req", mem_req, 1);
    check("store_mem_we", mem_we, 1);
    check("store_rf_we", rf_we, 0);
    tick();
    clear_dec();
    check("store_after_mem_req", mem_req, 0);
    check("store_after_mem_we", mem_we, 0);
    check("store_pc", pc, 25);
    check("count_after_store", instr_count, exp_cnt(8));

    // pc wrap at 1023
    do_alu(10'd25, 1, 1, 10'd1023, 0);
    do_alu(10'd1023, 0, 0, 10'd0, 1);
    check("wrap_pc", pc, 0);

    // reset in the middle of a store
    mem_write = 1;
    tick();                                   // DECODE
    tick();                                   // MEM
    check("pre_rst_mem_req", mem_req, 1);
    check("pre_rst_mem_we", mem_we, 1);
    reset = 1;
    #1;
    check("midmem_rst_mem_req", mem_req, 0);
    check("midmem_rst_mem_we", mem_we, 0);
    check("midmem_rst_busy", busy, 0);
    check("midmem_rst_rf_we", rf_we, 0);
    check("midmem_rst_count", instr_count, 0);
    clear_dec();
    tick();
    reset = 0;
    tick();
    check("post_rst_pc", pc, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
